// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper
// for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int DATA_W  = 16;
  localparam int ID_W    = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic {RUN, REPLAY} arb_state_e;

  typedef struct packed {
    logic              v;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } slot_t;

  // Returns {hit, index} of the first set bit at or after ptr, modulo n.
  function automatic logic [ID_W:0] rr_pick(
    input logic [MAX_REQ-1:0] mask,
    input logic [ID_W-1:0]    ptr,
    input int                 n
  );
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % n);
      if (k < n && !res[ID_W] && mask[idx])
        res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle
// seen by the write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_done;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          almostfull;
  logic                          wr_ack;
  logic                          overflow;
  logic [CNT_W-1:0]              replay_cnt;
  logic                          busy;

  modport master (
    input  req_valid, req_data, full, almostfull,
    input  wr_ack, overflow,
    output req_ready, req_done, wr_en, data_in,
    output replay_cnt, busy
  );

  modport slave (
    output req_valid, req_data, full, almostfull,
    output wr_ack, overflow,
    input  req_ready, req_done, wr_en, data_in,
    input  replay_cnt, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter with one-hot grant
// starting the search at ptr.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);
  logic [MAX_REQ-1:0] mask;
  logic [ID_W:0]      pick;

  always_comb begin
    mask = '0;
    mask[NUM_REQ-1:0] = req;
    pick = rr_pick(mask, ptr, NUM_REQ);
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      gnt[i] = en & pick[ID_W] &
               (pick[ID_W-1:0] == ID_W'(i));
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between producers and
// replays overflowed beats in acceptance order.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = DATA_W,
  parameter int CNT_W      = 8
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master bus
);
  arb_state_e         state, state_n;
  slot_t              s1, s2, r0, r1;
  slot_t              s1_n, s2_n, r0_n, r1_n;
  logic [ID_W-1:0]    ptr, ptr_n, win;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt, done;
  logic               ack_ok, bad;
  logic               can_issue, arb_en;

  // A due response that is not a clean ack counts as overflow.
  assign ack_ok = s2.v & bus.wr_ack & ~bus.overflow;
  assign bad    = s2.v & ~ack_ok;

  assign can_issue = ~bus.full &
    (~bus.almostfull | (~s1.v & ~s2.v));
  assign arb_en = rst_n & (state == RUN) &
    can_issue & ~bad;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) win = ID_W'(i);
  end

  always_comb begin
    state_n = state;
    s1_n    = '0;
    s2_n    = s1;
    r0_n    = r0;
    r1_n    = r1;
    ptr_n   = ptr;
    cnt_n   = cnt;
    done    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      done[i] = rst_n & ack_ok & (s2.id == ID_W'(i));
    unique case (state)
      RUN: begin
        if (bad) begin
          r0_n    = s2;
          r1_n    = s1;
          s2_n    = '0;
          state_n = REPLAY;
        end else if (|gnt) begin
          s1_n.v    = 1'b1;
          s1_n.id   = win;
          s1_n.data = bus.req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
          ptr_n = (int'(win) == NUM_REQ-1) ? '0 : win + 1'b1;
        end
      end
      REPLAY: begin
        if (ack_ok) begin
          r0_n = r1;
          r1_n = '0;
        end
        // R0 stays put until acked, so a retry needs no extra copy.
        if (!bus.full && !s1.v && !s2.v && r0.v) begin
          s1_n = r0;
          if (cnt != '1) cnt_n = cnt + 1'b1;
        end
        if (!r0_n.v && !r1_n.v) state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      s1    <= '0;
      s2    <= '0;
      r0    <= '0;
      r1    <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      s1    <= s1_n;
      s2    <= s2_n;
      r0    <= r0_n;
      r1    <= r1_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.req_done   = done;
  assign bus.wr_en      = s1.v;
  assign bus.data_in    = s1.data;
  assign bus.replay_cnt = cnt;
  assign bus.busy = s1.v | s2.v | r0.v | r1.v |
                    (state == REPLAY);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter
// against a queue-based transaction model.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  typedef struct {
    int          id;
    logic [15:0] d;
    int          t;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_W(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  beat_t fly[$];
  beat_t rq[$];
  bit    rmode = 0;
  int    m_ptr = 0;
  int    m_cnt = 0;
  int    e = 0;

  bit          pend[N];
  logic [15:0] pdata[N];
  int          acc_n[N];
  int          obs_dcnt[N];

  bit rnd = 0, ovf_next = 0, drop_next = 0;
  logic full_i = 0, af_i = 0;

  logic        obs_wren;
  logic [15:0] obs_data;
  logic [N-1:0] obs_ready, obs_dvec;
  logic [15:0] obs_wr[$];
  int          obs_done[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    beat_t due, bb;
    bit has_due, has_bus, ok, bad;
    int win, pipe_n;
    logic [N-1:0] exp_ready, exp_done;
    if (rnd) begin
      full_i = ($urandom % 8) == 0;
      af_i   = ($urandom % 4) == 0;
      for (int j = 0; j < N; j++)
        if (!pend[j] && $urandom % 2 == 1) begin
          pend[j] = 1;
          pdata[j] = 16'($urandom);
        end
      win = $urandom % 10;
      ovf_next  = win == 0;
      drop_next = win == 1;
    end
    has_due = 0;
    has_bus = 0;
    foreach (fly[k]) begin
      if (fly[k].t + 1 == e) begin has_due = 1; due = fly[k]; end
      if (fly[k].t == e) begin has_bus = 1; bb = fly[k]; end
    end
    bus.full = full_i;
    bus.almostfull = af_i;
    bus.wr_ack = has_due && !ovf_next && !drop_next;
    bus.overflow = has_due && ovf_next;
    for (int j = 0; j < N; j++) begin
      bus.req_valid[j] = pend[j];
      bus.req_data[j*W +: W] = pdata[j];
    end
    #1;
    ok  = has_due && bus.wr_ack && !bus.overflow;
    bad = has_due && !ok;
    exp_done = '0;
    if (ok && rst_n) exp_done[due.id] = 1'b1;
    exp_ready = '0;
    win = -1;
    if (rst_n && !rmode && !bad && !full_i &&
        (!af_i || fly.size() == 0))
      for (int k = 0; k < N; k++)
        if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("ready", bus.req_ready, exp_ready);
    chk("done", bus.req_done, exp_done);
    chk("wr_en", bus.wr_en, has_bus);
    if (has_bus) chk("data_in", bus.data_in, bb.d);
    chk("replay_cnt", bus.replay_cnt, m_cnt);
    chk("busy", bus.busy,
        fly.size() > 0 || rq.size() > 0 || rmode);
    obs_wren = bus.wr_en;
    obs_data = bus.data_in;
    obs_ready = bus.req_ready;
    obs_dvec = bus.req_done;
    if (bus.wr_en) obs_wr.push_back(bus.data_in);
    for (int j = 0; j < N; j++)
      if (bus.req_done[j]) begin
        obs_done.push_back(j);
        obs_dcnt[j]++;
      end
    pipe_n = fly.size();
    if (!rst_n) begin
      fly.delete();
      rq.delete();
      rmode = 0;
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      for (int k = 0; k < fly.size(); k++)
        if (fly[k].t + 1 == e) begin fly.delete(k); break; end
      if (!rmode) begin
        if (bad) begin
          rq.push_back(due);
          if (has_bus) rq.push_back(bb);
          fly.delete();
          rmode = 1;
        end else if (win >= 0) begin
          fly.push_back('{win, pdata[win], e + 1});
          m_ptr = (win + 1) % N;
          pend[win] = 0;
          acc_n[win]++;
        end
      end else begin
        if (ok) void'(rq.pop_front());
        else if (!full_i && pipe_n == 0 && rq.size() > 0) begin
          fly.push_back('{rq[0].id, rq[0].d, e + 1});
          if (m_cnt < 255) m_cnt++;
        end
        if (rq.size() == 0) rmode = 0;
      end
    end
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < N; j++) pend[j] = 0;
    repeat (n) step();
  endtask

  initial begin
    int last;
    for (int j = 0; j < N; j++) begin
      pend[j] = 0; pdata[j] = '0; acc_n[j] = 0; obs_dcnt[j] = 0;
    end
    bus.req_valid = '0; bus.req_data = '0; bus.full = 0;
    bus.almostfull = 0; bus.wr_ack = 0; bus.overflow = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_cnt", bus.replay_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1;

    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < N; j++)
        if (!pend[j]) begin pend[j] = 1; pdata[j] = 16'(j*256 + k); end
      step();
      chk("rr_order", obs_ready, 4'b0001 << (k % 4));
    end
    idle(3);

    pend[2] = 1; pdata[2] = 16'hA5A5;
    step();
    step();
    chk("single_wr", obs_wren, 1);
    chk("single_data", obs_data, 16'hA5A5);
    step();
    chk("single_done", obs_dvec, 4'b0100);
    idle(2);

    af_i = 1;
    last = -10;
    for (int k = 0; k < 15; k++) begin
      for (int j = 0; j < N; j++)
        if (!pend[j]) begin pend[j] = 1; pdata[j] = 16'($urandom); end
      step();
      if (obs_wren) begin
        chk("af_gap", (k - last) >= 3, 1);
        last = k;
      end
    end
    full_i = 1;
    repeat (4) begin
      step();
      chk("full_ready", obs_ready, 0);
    end
    full_i = 0; af_i = 0;
    idle(4);

    pend[0] = 1; pdata[0] = 16'h1111;
    step();
    pend[1] = 1; pdata[1] = 16'h2222;
    step();
    ovf_next = 1;
    step();
    ovf_next = 0;
    obs_wr.delete();
    obs_done.delete();
    idle(10);
    chk("rp_n", obs_wr.size(), 2);
    if (obs_wr.size() == 2) begin
      chk("rp_first", obs_wr[0], 16'h1111);
      chk("rp_second", obs_wr[1], 16'h2222);
    end
    chk("rp_cnt", bus.replay_cnt, 2);
    chk("rp_done_n", obs_done.size(), 2);
    if (obs_done.size() == 2) begin
      chk("rp_done0", obs_done[0], 0);
      chk("rp_done1", obs_done[1], 1);
    end
    chk("rp_idle", bus.busy, 0);

    pend[0] = 1; pdata[0] = 16'h3333;
    step();
    pend[1] = 1; pdata[1] = 16'h4444;
    step();
    ovf_next = 1;
    step();
    ovf_next = 0;
    full_i = 1;
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rr_wr_en", bus.wr_en, 0);
    chk("rr_busy", bus.busy, 0);
    full_i = 0;
    obs_done.delete();
    idle(6);
    chk("rr_no_done", obs_done.size(), 0);

    for (int j = 0; j < N; j++) begin acc_n[j] = 0; obs_dcnt[j] = 0; end
    rnd = 1;
    repeat (600) step();
    rnd = 0; full_i = 0; af_i = 0; ovf_next = 0; drop_next = 0;
    idle(30);
    for (int j = 0; j < N; j++)
      chk($sformatf("done_total%0d", j), obs_dcnt[j], acc_n[j]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
